// File: rtl/snake_step_engine.sv
// Snake game step engine: synchronises the slow game tick and advances the snake
// one grid cell per tick, tracking direction, length, score, food and self-collision.
module snake_step_engine #(
   parameter int GRID_W   = 16,
   parameter int GRID_H   = 8,
   parameter int XW       = 4,
   parameter int YW       = 3,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3
) (
   input  logic          clk_ht,
   input  logic          rst,
   input  logic          tick_in,
   input  logic          start,
   input  logic [3:0]    dir_btn,
   input  logic [XW-1:0] food_x,
   input  logic [YW-1:0] food_y,
   input  logic [3:0]    body_idx,
   output logic [XW-1:0] body_x,
   output logic [YW-1:0] body_y,
   output logic [XW-1:0] head_x,
   output logic [YW-1:0] head_y,
   output logic [4:0]    length,
   output logic [7:0]    score,
   output logic          step_pulse,
   output logic          eat_pulse,
   output logic          game_over
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
   localparam logic [YW-1:0] Y_INIT   = YW'(GRID_H / 2);
   localparam logic [4:0]    LEN_INIT = 5'(INIT_LEN);
   localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

   state_t        state;
   state_t        state_next;
   dir_t          dir;
   dir_t          pending_dir;
   dir_t          req_dir;
   dir_t          dir_eff;
   logic          req_valid;
   logic          s1;
   logic          s2;
   logic          s3;
   logic          rise;
   logic          do_step;
   logic          do_init;
   logic [XW-1:0] seg_x [MAX_LEN];
   logic [YW-1:0] seg_y [MAX_LEN];
   logic [XW-1:0] next_x;
   logic [YW-1:0] next_y;
   logic          eat;
   logic          collide;
   logic [4:0]    hit_lim;

   function automatic logic [XW-1:0] init_x(input int k);
      return XW'((((GRID_W / 2) - k) % GRID_W + GRID_W) % GRID_W);
   endfunction

   function automatic logic is_opposite(input dir_t a, input dir_t b);
      return (a == D_UP    && b == D_DOWN)  || (a == D_DOWN  && b == D_UP) ||
             (a == D_LEFT  && b == D_RIGHT) || (a == D_RIGHT && b == D_LEFT);
   endfunction

   // The registered rise adds one stage so a step lands three edges after tick_in is sampled.
   always_ff @(posedge clk_ht or posedge rst) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= tick_in;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
      end
   end

   always_ff @(posedge clk_ht or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      do_step    = 1'b0;
      do_init    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_RUN;
         end
         S_RUN: begin
            if (!start && rise) begin
               do_step = 1'b1;
               if (collide) state_next = S_OVER;
            end
         end
         S_OVER: begin
            if (start) begin
               do_init    = 1'b1;
               state_next = S_RUN;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      next_x = seg_x[0];
      next_y = seg_y[0];
      case (pending_dir)
         D_UP:    next_y = (seg_y[0] == '0)    ? Y_MAX : seg_y[0] - YW'(1);
         D_DOWN:  next_y = (seg_y[0] == Y_MAX) ? '0    : seg_y[0] + YW'(1);
         D_LEFT:  next_x = (seg_x[0] == '0)    ? X_MAX : seg_x[0] - XW'(1);
         default: next_x = (seg_x[0] == X_MAX) ? '0    : seg_x[0] + XW'(1);
      endcase
   end

   // When eating, the tail stays put, so it counts as an obstacle.
   always_comb begin
      eat     = (next_x == food_x) && (next_y == food_y);
      hit_lim = eat ? (length - 5'd1) : (length - 5'd2);
      collide = 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if ((5'(k) <= hit_lim) && (seg_x[k] == next_x) && (seg_y[k] == next_y))
            collide = 1'b1;
      end
   end

   always_comb begin
      req_valid = |dir_btn;
      req_dir   = D_RIGHT;
      if (dir_btn[3])      req_dir = D_UP;
      else if (dir_btn[2]) req_dir = D_DOWN;
      else if (dir_btn[1]) req_dir = D_LEFT;
      dir_eff = do_step ? pending_dir : dir;
   end

   always_ff @(posedge clk_ht or posedge rst) begin
      if (rst) begin
         pending_dir <= D_RIGHT;
      end else if (do_init) begin
         pending_dir <= D_RIGHT;
      end else if (req_valid && !is_opposite(req_dir, dir_eff)) begin
         pending_dir <= req_dir;
      end
   end

   always_ff @(posedge clk_ht or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < MAX_LEN; k++) begin
            seg_x[k] <= init_x(k);
            seg_y[k] <= Y_INIT;
         end
         dir        <= D_RIGHT;
         length     <= LEN_INIT;
         score      <= 8'd0;
         step_pulse <= 1'b0;
         eat_pulse  <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         eat_pulse  <= 1'b0;
         if (do_init) begin
            for (int k = 0; k < MAX_LEN; k++) begin
               seg_x[k] <= init_x(k);
               seg_y[k] <= Y_INIT;
            end
            dir    <= D_RIGHT;
            length <= LEN_INIT;
            score  <= 8'd0;
         end else if (do_step) begin
            step_pulse <= 1'b1;
            if (!collide) begin
               for (int k = MAX_LEN - 1; k > 0; k--) begin
                  seg_x[k] <= seg_x[k-1];
                  seg_y[k] <= seg_y[k-1];
               end
               seg_x[0] <= next_x;
               seg_y[0] <= next_y;
               dir      <= pending_dir;
               if (eat) begin
                  eat_pulse <= 1'b1;
                  if (length < LEN_MAX) length <= length + 5'd1;
                  if (score != 8'hFF)   score  <= score + 8'd1;
               end
            end
         end
      end
   end

   assign head_x    = seg_x[0];
   assign head_y    = seg_y[0];
   assign body_x    = seg_x[body_idx];
   assign body_y    = seg_y[body_idx];
   assign game_over = (state == S_OVER);

endmodule
